// File: rtl/reg_dump_controller_pkg.sv
// Shared types and constants for the register-dump debug sequencer.
package reg_dump_controller_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned PC_W   = 32;

  typedef enum logic [2:0] {
    DUMP_IDLE,
    DUMP_DRAIN,
    DUMP_READ,
    DUMP_SEND,
    DUMP_LOAD_PC,
    DUMP_SEND_PC,
    DUMP_DONE
  } dump_state_e;

endpackage

// File: rtl/reg_dump_controller_if.sv
// Read-port override and debug word stream between the dump sequencer and its neighbours.
interface reg_dump_controller_if #(
  parameter int unsigned DATA_W = 32
);

  logic                                       o_rd_sel;
  logic [reg_dump_controller_pkg::ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0]                          i_rd_data;
  logic                                       o_dbg_valid;
  logic [DATA_W-1:0]                          o_dbg_data;
  logic                                       i_dbg_ready;

  modport master (
    output o_rd_sel, o_rd_addr, o_dbg_valid, o_dbg_data,
    input  i_rd_data, i_dbg_ready
  );

  modport slave (
    input  o_rd_sel, o_rd_addr, o_dbg_valid, o_dbg_data,
    output i_rd_data, i_dbg_ready
  );

endinterface

// File: rtl/reg_dump_controller.sv
// Halts the pipeline and streams the register bank out one word per handshake.
// Optional macro REG_DUMP_PC_EN appends the PC captured at request acceptance as a final word.
module reg_dump_controller
  import reg_dump_controller_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_dump_req,
  input  logic [PC_W-1:0]              i_pc,
  output logic                         o_stall,
  output logic                         o_busy,
  output logic                         o_done,
  reg_dump_controller_if.master        bus
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  DRAIN_END = CNT_W'(DRAIN_CYCLES - 1);

  dump_state_e        r_state;
  dump_state_e        w_next;
  logic [ADDR_W-1:0]  r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_data;
  logic               w_start;
  logic               w_advance;

`ifdef REG_DUMP_PC_EN
  logic [PC_W-1:0]    r_pc;
`else
  logic               w_unused_pc;
  assign w_unused_pc = ^i_pc;
`endif

  // State register plus index, drain counter, data and PC capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= DUMP_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
`ifdef REG_DUMP_PC_EN
      r_pc    <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_idx <= '0;
        r_cnt <= '0;
`ifdef REG_DUMP_PC_EN
        r_pc  <= i_pc;
`endif
      end
      if (r_state == DUMP_DRAIN) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == DUMP_READ) r_data <= bus.i_rd_data;
      if (w_advance) r_idx <= r_idx + ADDR_W'(1);
`ifdef REG_DUMP_PC_EN
      // PC gets its own load cycle so every word keeps the two-cycle cadence
      if (r_state == DUMP_LOAD_PC) r_data <= DATA_W'(r_pc);
`endif
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next          = r_state;
    w_start         = 1'b0;
    w_advance       = 1'b0;
    o_stall         = 1'b1;
    o_busy          = 1'b1;
    o_done          = 1'b0;
    bus.o_rd_sel    = 1'b0;
    bus.o_rd_addr   = '0;
    bus.o_dbg_valid = 1'b0;
    bus.o_dbg_data  = '0;
    case (r_state)
      DUMP_IDLE: begin
        o_stall = 1'b0;
        o_busy  = 1'b0;
        if (i_dump_req) begin
          w_start = 1'b1;
          w_next  = DUMP_DRAIN;
        end
      end
      DUMP_DRAIN: begin
        if (r_cnt == DRAIN_END) w_next = DUMP_READ;
      end
      DUMP_READ: begin
        bus.o_rd_sel  = 1'b1;
        bus.o_rd_addr = r_idx;
        w_next        = DUMP_SEND;
      end
      DUMP_SEND: begin
        bus.o_dbg_valid = 1'b1;
        bus.o_dbg_data  = r_data;
        if (bus.i_dbg_ready) begin
          if (r_idx == LAST_IDX) begin
`ifdef REG_DUMP_PC_EN
            w_next = DUMP_LOAD_PC;
`else
            w_next = DUMP_DONE;
`endif
          end else begin
            w_advance = 1'b1;
            w_next    = DUMP_READ;
          end
        end
      end
`ifdef REG_DUMP_PC_EN
      DUMP_LOAD_PC: begin
        w_next = DUMP_SEND_PC;
      end
      DUMP_SEND_PC: begin
        bus.o_dbg_valid = 1'b1;
        bus.o_dbg_data  = r_data;
        if (bus.i_dbg_ready) w_next = DUMP_DONE;
      end
`endif
      DUMP_DONE: begin
        o_done = 1'b1;
        w_next = DUMP_IDLE;
      end
      default: begin
        w_next = DUMP_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump_controller.sv
// Randomized self-checking bench for reg_dump_controller against a word-list/cycle-count model.
module tb_reg_dump_controller;

  localparam int NREG = 32;
`ifdef REG_DUMP_PC_EN
  localparam int PCW = 1;
`else
  localparam int PCW = 0;
`endif
  // Model: drain 4, then 2 cycles per word, then DONE; waits add one cycle each
  localparam int DONE_BASE = 4 + 2 * (NREG + PCW) + 1;

  logic        clk;
  logic        reset;
  logic        i_dump_req, i_dump_req1;
  logic [31:0] i_pc;
  logic        s0_stall, s0_busy, s0_done;
  logic        s1_stall, s1_busy, s1_done;
  logic [31:0] bank [NREG];

  reg_dump_controller_if #(.DATA_W(32)) bus0 ();
  reg_dump_controller_if #(.DATA_W(32)) bus1 ();

  reg_dump_controller #(.NUM_REGS(NREG), .DATA_W(32), .DRAIN_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .i_dump_req(i_dump_req), .i_pc(i_pc),
    .o_stall(s0_stall), .o_busy(s0_busy), .o_done(s0_done), .bus(bus0));

  reg_dump_controller #(.NUM_REGS(NREG), .DATA_W(32), .DRAIN_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .i_dump_req(i_dump_req1), .i_pc(i_pc),
    .o_stall(s1_stall), .o_busy(s1_busy), .o_done(s1_done), .bus(bus1));

  assign bus0.i_rd_data = bank[bus0.o_rd_addr];
  assign bus1.i_rd_data = bank[bus1.o_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  int          obs_words [$];
  logic [31:0] exp_words [$];
  int          obs_first_valid, obs_done_cycle, obs_done_count, obs_stall_low;
  int          obs_hold_err, obs_waits;
  logic        obs_busy1, obs_busy_low;
  logic [41:0] obs_rst_vec;
  logic [31:0] obs_pc;

  task automatic fill_bank(input bit rnd);
    for (int i = 0; i < NREG; i++) bank[i] = rnd ? 32'($urandom) : 32'h1000_0000 + 32'(i);
    bank[0] = 32'h0;
  endtask

  task automatic build_expected();
    exp_words.delete();
    for (int i = 0; i < NREG; i++) exp_words.push_back(bank[i]);
    if (PCW == 1) exp_words.push_back(obs_pc);
  endtask

  // Drives one dump on u_dut and records what was observed; comparisons live in the tests
  task automatic run_dump(input int mode, input int req_word, input int rst_word, input bit hold);
    bit          hold_pend;
    logic [31:0] prev;
    int          w5;
    bit          rdy;
    hold_pend = 1'b0; prev = '0; w5 = 0;
    obs_words.delete();
    obs_first_valid = -1; obs_done_cycle = -1; obs_done_count = 0; obs_stall_low = -1;
    obs_hold_err = 0; obs_waits = 0; obs_busy1 = 1'b0; obs_busy_low = 1'b1; obs_rst_vec = '1;
    @(negedge clk);
    obs_pc = 32'($urandom);
    i_pc = obs_pc;
    i_dump_req = 1'b1;
    bus0.i_dbg_ready = 1'b1;
    @(negedge clk);
    i_pc = 32'($urandom);
    for (int n = 1; n <= 400; n++) begin
      if (n > 1) @(negedge clk);
      i_dump_req = hold;
      if (n == 1) obs_busy1 = s0_busy;
      if (hold_pend && !(bus0.o_dbg_valid && bus0.o_dbg_data == prev)) obs_hold_err++;
      if (bus0.o_dbg_valid && obs_first_valid < 0) obs_first_valid = n;
      if (s0_done) begin
        obs_done_count++;
        if (obs_done_cycle < 0) obs_done_cycle = n;
      end
      if (!s0_stall) begin
        obs_stall_low = n;
        obs_busy_low = s0_busy;
        break;
      end
      if (bus0.o_dbg_valid && obs_words.size() == rst_word) begin
        reset = 1'b0;
        @(negedge clk);
        obs_rst_vec = {s0_stall, s0_busy, s0_done, bus0.o_rd_sel, bus0.o_rd_addr,
                       bus0.o_dbg_valid, bus0.o_dbg_data};
        reset = 1'b1;
        break;
      end
      rdy = 1'b1;
      if (bus0.o_dbg_valid) begin
        if (mode == 1 && obs_words.size() == 5 && w5 < 3) begin rdy = 1'b0; w5++; end
        if (mode == 2) rdy = ($urandom_range(0, 3) != 0);
        if (obs_words.size() == req_word) i_dump_req = 1'b1;
      end
      bus0.i_dbg_ready = rdy;
      hold_pend = bus0.o_dbg_valid && !rdy;
      prev = bus0.o_dbg_data;
      if (bus0.o_dbg_valid && rdy) obs_words.push_back(int'(bus0.o_dbg_data));
      if (bus0.o_dbg_valid && !rdy) obs_waits++;
    end
    bus0.i_dbg_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({s0_stall, s0_busy, s0_done, bus0.o_rd_sel, bus0.o_rd_addr, bus0.o_dbg_valid,
         bus0.o_dbg_data} !== 42'h0) begin
      n_mis++;
      $display("FAIL reset_outputs: stall=%b busy=%b done=%b sel=%b valid=%b data=%h, required all 0",
               s0_stall, s0_busy, s0_done, bus0.o_rd_sel, bus0.o_dbg_valid, bus0.o_dbg_data);
    end
    n_cmp++;
    if ({s1_stall, s1_busy, s1_done, bus1.o_dbg_valid} !== 4'h0) begin
      n_mis++;
      $display("FAIL reset_outputs_d1: got %b, required 0000", {s1_stall, s1_busy, s1_done, bus1.o_dbg_valid});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_dump();
    int bad;
    fill_bank(1'b0);
    run_dump(0, -1, -1, 1'b0);
    build_expected();
    n_cmp++;
    if (obs_busy1 !== 1'b1) begin n_mis++; $display("FAIL full_busy_c1: got %b, required 1", obs_busy1); end
    n_cmp++;
    if (obs_first_valid !== 6) begin n_mis++; $display("FAIL full_first_valid: got %0d, required 6", obs_first_valid); end
    n_cmp++;
    if (obs_done_cycle !== DONE_BASE) begin n_mis++; $display("FAIL full_done_cycle: got %0d, required %0d", obs_done_cycle, DONE_BASE); end
    n_cmp++;
    if (obs_stall_low !== DONE_BASE + 1) begin n_mis++; $display("FAIL full_stall_low: got %0d, required %0d", obs_stall_low, DONE_BASE + 1); end
    n_cmp++;
    if (obs_busy_low !== 1'b0) begin n_mis++; $display("FAIL full_busy_idle: got %b, required 0", obs_busy_low); end
    n_cmp++;
    if (obs_words.size() !== exp_words.size()) begin
      n_mis++; $display("FAIL full_word_count: got %0d, required %0d", obs_words.size(), exp_words.size());
    end else begin
      bad = -1;
      for (int i = 0; i < exp_words.size(); i++) if (bad < 0 && 32'(obs_words[i]) !== exp_words[i]) bad = i;
      n_cmp++;
      if (bad >= 0) begin
        n_mis++; $display("FAIL full_words: word %0d got %h, required %h", bad, 32'(obs_words[bad]), exp_words[bad]);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    fill_bank(1'b0);
    run_dump(1, -1, -1, 1'b0);
    build_expected();
    n_cmp++;
    if (obs_hold_err !== 0) begin n_mis++; $display("FAIL bp_hold: %0d unstable cycles, required 0", obs_hold_err); end
    n_cmp++;
    if (obs_done_cycle !== DONE_BASE + 3) begin n_mis++; $display("FAIL bp_done_cycle: got %0d, required %0d", obs_done_cycle, DONE_BASE + 3); end
    bad = (obs_words.size() == exp_words.size()) ? -1 : -2;
    if (bad == -1) for (int i = 0; i < exp_words.size(); i++) if (bad < 0 && 32'(obs_words[i]) !== exp_words[i]) bad = i;
    n_cmp++;
    if (bad != -1) begin n_mis++; $display("FAIL bp_words: count %0d first bad %0d, required %0d exact words", obs_words.size(), bad, exp_words.size()); end
  endtask

  task automatic test_random_backpressure();
    int bad;
    for (int it = 0; it < 3; it++) begin
      fill_bank(1'b1);
      run_dump(2, -1, -1, 1'b0);
      build_expected();
      n_cmp++;
      if (obs_hold_err !== 0) begin n_mis++; $display("FAIL rnd_hold[%0d]: %0d unstable cycles, required 0", it, obs_hold_err); end
      n_cmp++;
      if (obs_done_cycle !== DONE_BASE + obs_waits) begin
        n_mis++; $display("FAIL rnd_done_cycle[%0d]: got %0d, required %0d", it, obs_done_cycle, DONE_BASE + obs_waits);
      end
      bad = (obs_words.size() == exp_words.size()) ? -1 : -2;
      if (bad == -1) for (int i = 0; i < exp_words.size(); i++) if (bad < 0 && 32'(obs_words[i]) !== exp_words[i]) bad = i;
      n_cmp++;
      if (bad != -1) begin n_mis++; $display("FAIL rnd_words[%0d]: count %0d first bad %0d, required %0d exact words", it, obs_words.size(), bad, exp_words.size()); end
    end
  endtask

  task automatic test_req_ignored();
    fill_bank(1'b1);
    run_dump(0, 10, -1, 1'b0);
    n_cmp++;
    if (obs_words.size() !== NREG + PCW) begin n_mis++; $display("FAIL ign_word_count: got %0d, required %0d", obs_words.size(), NREG + PCW); end
    n_cmp++;
    if (obs_done_count !== 1) begin n_mis++; $display("FAIL ign_done_count: got %0d, required 1", obs_done_count); end
    n_cmp++;
    if (obs_stall_low !== DONE_BASE + 1) begin n_mis++; $display("FAIL ign_stall_low: got %0d, required %0d", obs_stall_low, DONE_BASE + 1); end
    @(negedge clk);
    n_cmp++;
    if (s0_busy !== 1'b0) begin n_mis++; $display("FAIL ign_not_queued: busy got %b, required 0", s0_busy); end
  endtask

  task automatic test_reset_mid_send();
    fill_bank(1'b1);
    run_dump(0, -1, 7, 1'b0);
    n_cmp++;
    if (obs_rst_vec !== 42'h0) begin n_mis++; $display("FAIL rst_mid_send: outputs got %h, required 0", obs_rst_vec); end
    n_cmp++;
    if (obs_words.size() !== 7) begin n_mis++; $display("FAIL rst_words_before: got %0d, required 7", obs_words.size()); end
    bank[0] = 32'h0;
    run_dump(0, -1, -1, 1'b0);
    build_expected();
    n_cmp++;
    if (obs_words.size() !== exp_words.size() || 32'(obs_words[0]) !== exp_words[0] ||
        32'(obs_words[1]) !== exp_words[1]) begin
      n_mis++; $display("FAIL rst_restart: count %0d, required %0d starting at r0", obs_words.size(), exp_words.size());
    end
    n_cmp++;
    if (obs_done_cycle !== DONE_BASE) begin n_mis++; $display("FAIL rst_restart_done: got %0d, required %0d", obs_done_cycle, DONE_BASE); end
  endtask

  task automatic test_held_req();
    fill_bank(1'b1);
    run_dump(0, -1, -1, 1'b1);
    n_cmp++;
    if (obs_stall_low !== DONE_BASE + 1) begin n_mis++; $display("FAIL held_stall_low: got %0d, required %0d", obs_stall_low, DONE_BASE + 1); end
    @(negedge clk);
    n_cmp++;
    if ({s0_stall, s0_busy} !== 2'b11) begin n_mis++; $display("FAIL held_restart: stall/busy got %b, required 11", {s0_stall, s0_busy}); end
    i_dump_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_drain1();
    int first_rd, first_valid;
    first_rd = -1; first_valid = -1;
    bus1.i_dbg_ready = 1'b1;
    @(negedge clk);
    i_dump_req1 = 1'b1;
    @(negedge clk);
    i_dump_req1 = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) @(negedge clk);
      if (bus1.o_rd_sel && first_rd < 0) first_rd = n;
      if (bus1.o_dbg_valid && first_valid < 0) first_valid = n;
    end
    n_cmp++;
    if (first_rd !== 2) begin n_mis++; $display("FAIL d1_first_read: got %0d, required 2", first_rd); end
    n_cmp++;
    if (first_valid !== 3) begin n_mis++; $display("FAIL d1_first_valid: got %0d, required 3", first_valid); end
  endtask

  initial begin
    reset = 1'b0;
    i_dump_req = 1'b0;
    i_dump_req1 = 1'b0;
    i_pc = '0;
    bus0.i_dbg_ready = 1'b1;
    bus1.i_dbg_ready = 1'b1;
    fill_bank(1'b0);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_random_backpressure();
    test_req_ignored();
    test_reset_mid_send();
    test_held_req();
    test_drain1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
